// File: rtl/chan_pattern_generator.sv
// Channel stimulus source for the logic analyzer: counter, walking-one, LFSR and
// UART 8N1 patterns, all advanced on a prescaled tick and driven from registers.
module chan_pattern_generator #(
    parameter int unsigned CHANNEL_COUNT = 8,
    parameter int unsigned TICK_DIV      = 1000,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1,
    parameter logic [7:0]  UART_SEED     = 8'h55
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [1:0]               mode,
    output logic [CHANNEL_COUNT-1:0] pattern_out,
    output logic                     tick,
    output logic                     wrap
);

    localparam int unsigned    PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        M_COUNT = 2'd0,
        M_WALK  = 2'd1,
        M_LFSR  = 2'd2,
        M_UART  = 2'd3
    } mode_t;

    typedef enum logic [3:0] {
        U_IDLE0, U_IDLE1, U_START,
        U_D0, U_D1, U_D2, U_D3, U_D4, U_D5, U_D6, U_D7,
        U_STOP
    } uart_state_t;

    logic [PW-1:0]            presc_q,   presc_d;
    logic [CHANNEL_COUNT-1:0] pattern_q, pattern_d;
    logic                     tick_q,    tick_d;
    logic                     wrap_q,    wrap_d;
    logic                     loaded_q,  loaded_d;
    mode_t                    cur_mode_q, cur_mode_d;
    logic [15:0]              lfsr_q,    lfsr_d;
    uart_state_t              ustate_q,  ustate_d;
    logic [7:0]               ubyte_q,   ubyte_d;

    logic [CHANNEL_COUNT-1:0] count_next;
    logic [CHANNEL_COUNT-1:0] walk_next;
    logic [15:0]              lfsr_next;
    uart_state_t              ustate_next;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    function automatic uart_state_t uart_step(input uart_state_t s);
        if (s >= U_STOP) begin
            return U_IDLE0;
        end
        return uart_state_t'(4'(s) + 4'd1);
    endfunction

    // ch0 = TX line, ch1 = frame active (START through D7)
    function automatic logic [CHANNEL_COUNT-1:0] uart_drive(input uart_state_t s,
                                                            input logic [7:0] b);
        logic [CHANNEL_COUNT-1:0] p;
        logic [2:0]               idx;
        p   = '0;
        idx = 3'(4'(s) - 4'(U_D0));
        case (s)
            U_IDLE0, U_IDLE1, U_STOP: p[0] = 1'b1;
            U_START:                  p[1] = 1'b1;
            default: begin
                p[0] = b[idx];
                p[1] = 1'b1;
            end
        endcase
        return p;
    endfunction

    always_comb begin
        presc_d    = presc_q;
        pattern_d  = pattern_q;
        tick_d     = 1'b0;
        wrap_d     = 1'b0;
        loaded_d   = loaded_q;
        cur_mode_d = cur_mode_q;
        lfsr_d     = lfsr_q;
        ustate_d   = ustate_q;
        ubyte_d    = ubyte_q;

        count_next  = pattern_q + CHANNEL_COUNT'(1);
        walk_next   = {pattern_q[CHANNEL_COUNT-2:0], pattern_q[CHANNEL_COUNT-1]};
        lfsr_next   = lfsr_step(lfsr_q);
        ustate_next = uart_step(ustate_q);

        if (enable) begin
            if (presc_q != PRESC_LAST) begin
                presc_d = presc_q + PW'(1);
            end else begin
                presc_d = '0;
                tick_d  = 1'b1;
                // A pending load outranks the advance, so a wrap on this tick is lost
                if (!loaded_q || (mode != cur_mode_q)) begin
                    loaded_d   = 1'b1;
                    cur_mode_d = mode_t'(mode);
                    case (mode_t'(mode))
                        M_COUNT: pattern_d = '0;
                        M_WALK:  pattern_d = CHANNEL_COUNT'(1);
                        M_LFSR: begin
                            lfsr_d    = LFSR_SEED;
                            pattern_d = LFSR_SEED[CHANNEL_COUNT-1:0];
                        end
                        M_UART: begin
                            ustate_d  = U_IDLE0;
                            ubyte_d   = UART_SEED;
                            pattern_d = uart_drive(U_IDLE0, UART_SEED);
                        end
                    endcase
                end else begin
                    case (cur_mode_q)
                        M_COUNT: begin
                            pattern_d = count_next;
                            wrap_d    = (count_next == '0);
                        end
                        M_WALK: begin
                            pattern_d = walk_next;
                            wrap_d    = (walk_next == CHANNEL_COUNT'(1));
                        end
                        M_LFSR: begin
                            lfsr_d    = lfsr_next;
                            pattern_d = lfsr_next[CHANNEL_COUNT-1:0];
                            wrap_d    = (lfsr_next == LFSR_SEED);
                        end
                        M_UART: begin
                            ustate_d  = ustate_next;
                            pattern_d = uart_drive(ustate_next, ubyte_q);
                            if (ustate_next == U_STOP) begin
                                wrap_d  = 1'b1;
                                ubyte_d = ubyte_q + 8'd1;
                            end
                        end
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q    <= '0;
            pattern_q  <= '0;
            tick_q     <= 1'b0;
            wrap_q     <= 1'b0;
            loaded_q   <= 1'b0;
            cur_mode_q <= M_COUNT;
            lfsr_q     <= LFSR_SEED;
            ustate_q   <= U_IDLE0;
            ubyte_q    <= UART_SEED;
        end else begin
            presc_q    <= presc_d;
            pattern_q  <= pattern_d;
            tick_q     <= tick_d;
            wrap_q     <= wrap_d;
            loaded_q   <= loaded_d;
            cur_mode_q <= cur_mode_d;
            lfsr_q     <= lfsr_d;
            ustate_q   <= ustate_d;
            ubyte_q    <= ubyte_d;
        end
    end

    assign pattern_out = pattern_q;
    assign tick        = tick_q;
    assign wrap        = wrap_q;

endmodule

// File: tb/tb_chan_pattern_generator.sv
// Directed bench for chan_pattern_generator: three instances (TICK_DIV 4, 1, 2)
// checked against a scoreboard of expected tick outputs.
module tb_chan_pattern_generator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, en_a, tick_a, wrap_a;
    logic [1:0] mode_a;
    logic [7:0] pat_a;
    logic       rst_l, en_l, tick_l, wrap_l;
    logic [1:0] mode_l;
    logic [7:0] pat_l;
    logic       rst_u, en_u, tick_u, wrap_u;
    logic [1:0] mode_u;
    logic [7:0] pat_u;

    chan_pattern_generator #(.CHANNEL_COUNT(8), .TICK_DIV(4)) dut_a (
        .clk(clk), .reset(rst_a), .enable(en_a), .mode(mode_a),
        .pattern_out(pat_a), .tick(tick_a), .wrap(wrap_a));

    chan_pattern_generator #(.CHANNEL_COUNT(8), .TICK_DIV(1)) dut_l (
        .clk(clk), .reset(rst_l), .enable(en_l), .mode(mode_l),
        .pattern_out(pat_l), .tick(tick_l), .wrap(wrap_l));

    chan_pattern_generator #(.CHANNEL_COUNT(8), .TICK_DIV(2)) dut_u (
        .clk(clk), .reset(rst_u), .enable(en_u), .mode(mode_u),
        .pattern_out(pat_u), .tick(tick_u), .wrap(wrap_u));

    int         sel;
    logic [7:0] obs_pat;
    logic       obs_tick, obs_wrap;

    always_comb begin
        obs_pat  = pat_a;
        obs_tick = tick_a;
        obs_wrap = wrap_a;
        case (sel)
            1: begin obs_pat = pat_l; obs_tick = tick_l; obs_wrap = wrap_l; end
            2: begin obs_pat = pat_u; obs_tick = tick_u; obs_wrap = wrap_u; end
            default: ;
        endcase
    end

    typedef struct packed {
        logic [7:0] pat;
        logic       wrap;
    } exp_t;

    exp_t  sbq[$];
    int    total = 0;
    int    bad   = 0;
    string ctx   = "init";

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s/%s: observed=%h expected=%h", ctx, tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] p, input logic w);
        exp_t e;
        e.pat  = p;
        e.wrap = w;
        sbq.push_back(e);
    endtask

    task automatic wait_tick(input int budget, output int c);
        c = 0;
        do begin
            @(negedge clk);
            c++;
            if (!obs_tick) check("wrap_without_tick", 16'(obs_wrap), 16'(0));
        end while (!obs_tick && c < budget);
        check("tick_seen", 16'(obs_tick), 16'(1));
    endtask

    task automatic drain(input int spacing);
        int   c;
        exp_t e;
        while (sbq.size() > 0) begin
            wait_tick(spacing + 2, c);
            check("tick_spacing", 16'(c), 16'(spacing));
            e = sbq.pop_front();
            check("pattern", 16'(obs_pat), 16'(e.pat));
            check("wrap", 16'(obs_wrap), 16'(e.wrap));
        end
    endtask

    task automatic check_reset_state(input int s);
        sel = s;
        #1;
        check("rst_pattern", 16'(obs_pat), 16'(0));
        check("rst_tick", 16'(obs_tick), 16'(0));
        check("rst_wrap", 16'(obs_wrap), 16'(0));
    endtask

    function automatic logic [15:0] lfsr_model(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    // Tick i (1..12) of a frame: IDLE, IDLE, START, D0..D7, STOP
    function automatic logic [7:0] uart_exp(input logic [7:0] b, input int i);
        logic tx, act;
        if (i <= 2) begin
            tx = 1'b1; act = 1'b0;
        end else if (i == 3) begin
            tx = 1'b0; act = 1'b1;
        end else if (i <= 11) begin
            tx = b[i-4]; act = 1'b1;
        end else begin
            tx = 1'b1; act = 1'b0;
        end
        return {6'b0, act, tx};
    endfunction

    initial begin
        logic [15:0] m;
        sel   = 0;
        rst_a = 1'b1; en_a = 1'b0; mode_a = 2'd0;
        rst_l = 1'b1; en_l = 1'b0; mode_l = 2'd2;
        rst_u = 1'b1; en_u = 1'b0; mode_u = 2'd3;
        repeat (3) @(negedge clk);
        ctx = "reset";
        check_reset_state(0);
        check_reset_state(1);
        check_reset_state(2);
        @(negedge clk);
        rst_a = 1'b0; rst_l = 1'b0; rst_u = 1'b0;

        // Counter: load 0x00, then 1..255, then 0x00 with wrap on 256th post-load tick
        ctx = "counter";
        sel = 0;
        @(negedge clk);
        en_a = 1'b1;
        push(8'h00, 1'b0);
        for (int k = 1; k <= 255; k++) push(8'(k), 1'b0);
        push(8'h00, 1'b1);
        push(8'h01, 1'b0);
        push(8'h02, 1'b0);
        drain(4);

        // Mode change mid-count restarts at walking-one seed without wrap
        ctx = "walk";
        mode_a = 2'd1;
        push(8'h01, 1'b0);
        push(8'h02, 1'b0);
        push(8'h04, 1'b0);
        push(8'h08, 1'b0);
        drain(4);

        ctx = "enable_gap";
        @(negedge clk);
        en_a = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("hold_tick", 16'(obs_tick), 16'(0));
            check("hold_pattern", 16'(obs_pat), 16'h08);
        end
        en_a = 1'b1;
        push(8'h10, 1'b0);
        drain(3);

        ctx = "walk_resume";
        push(8'h20, 1'b0);
        push(8'h40, 1'b0);
        push(8'h80, 1'b0);
        push(8'h01, 1'b1);
        push(8'h02, 1'b0);
        push(8'h04, 1'b0);
        push(8'h08, 1'b0);
        push(8'h10, 1'b0);
        push(8'h20, 1'b0);
        push(8'h40, 1'b0);
        push(8'h80, 1'b0);
        drain(4);

        // Mode change lands on what would be the wrap tick: load wins
        ctx = "load_on_wrap";
        mode_a = 2'd0;
        push(8'h00, 1'b0);
        push(8'h01, 1'b0);
        drain(4);
        en_a = 1'b0;

        // LFSR at one tick per cycle, full period
        ctx = "lfsr";
        sel = 1;
        #1;
        en_l = 1'b1;
        push(8'hE1, 1'b0);
        push(8'hC3, 1'b0);
        drain(1);
        m = 16'h59C3;
        for (int k = 2; k <= 65535; k++) begin
            m = lfsr_model(m);
            push(m[7:0], k == 65535);
            drain(1);
        end
        push(8'hC3, 1'b0);
        drain(1);
        @(negedge clk);
        en_l = 1'b0;

        // UART frames 0x55 then 0x56
        ctx = "uart";
        sel = 2;
        #1;
        en_u = 1'b1;
        for (int f = 0; f < 2; f++) begin
            for (int i = 1; i <= 12; i++) push(uart_exp(8'h55 + 8'(f), i), i == 12);
        end
        for (int i = 1; i <= 5; i++) push(uart_exp(8'h57, i), 1'b0);
        drain(2);

        // One-cycle reset mid-frame, then restart at IDLE0 with the seed byte
        ctx = "uart_reset";
        rst_u = 1'b1;
        @(negedge clk);
        check("rst_pattern", 16'(obs_pat), 16'(0));
        check("rst_tick", 16'(obs_tick), 16'(0));
        check("rst_wrap", 16'(obs_wrap), 16'(0));
        rst_u = 1'b0;
        for (int i = 1; i <= 12; i++) push(uart_exp(8'h55, i), i == 12);
        drain(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/chan_pattern_generator.md
Name: chan_pattern_generator

Overview:
- Drives known, repeatable digital patterns onto the logic analyzer's `chan_in` inputs, which makes it the transmit/stimulus end of the channel-capture path.
- Used for bring-up, self-test and demo: its output wires straight to the analyzer channels, on-chip or looped out through header pins.
- Produces four selectable patterns: binary counter, walking one, 16-bit LFSR, and a UART-style 8N1 serial frame.
- Patterns advance only on a programmable prescaled tick, so the pattern rate can be matched to the analyzer sample rate.

Parameters:
- CHANNEL_COUNT, 8: width of `pattern_out`. Legal range 2..16.
- TICK_DIV, 1000: clock cycles per pattern tick. Must be ≥ 1.
- LFSR_SEED, 16'hACE1: LFSR load value. Must be non-zero.
- UART_SEED, 8'h55: first byte sent after UART mode loads.

Ports:
- clk  input  1  system clock.
- reset  input  1  reset, synchronous, active-high.
- enable  input  1  run; when low, the prescaler and all pattern state hold.
- mode  input  2  0=counter, 1=walking one, 2=LFSR, 3=UART.
- pattern_out  output  CHANNEL_COUNT  channel drive, registered.
- tick  output  1  one-cycle pulse, coincident with each `pattern_out` update.
- wrap  output  1  one-cycle pulse marking a pattern-sequence restart.

Behaviour:
- One clock (`clk`). Reset is synchronous and active-high (`reset`), sampled on the `clk` rising edge. It has priority over everything else.
- Reset values: `pattern_out`=0, `tick`=0, `wrap`=0, prescaler=0, `loaded`=0, `cur_mode`=0, LFSR=LFSR_SEED, UART state=IDLE0, uart_byte=UART_SEED.
- Prescaler: counts 0..TICK_DIV-1 while `enable`=1. At TICK_DIV-1 with `enable`=1, the next edge sets prescaler←0 and performs a tick update (below).
  - The first tick therefore lands TICK_DIV edges after `enable` is first sampled high.
  - TICK_DIV=1 gives a tick on every enabled cycle.
  - `enable`=0 freezes the prescaler and all state; `tick` and `wrap` are 0.
- Tick update: `tick`←1 for exactly one cycle. `wrap`←0 unless stated otherwise below. `mode` is sampled only at tick updates.
- Load: if `loaded`=0 or `mode`≠`cur_mode`, then `cur_mode`←`mode`, `loaded`←1, the mode seed is loaded and output, and `wrap`=0. A mode change mid-sequence therefore takes effect at the next tick, restarting from the seed.
- Mode 0 (counter):
  - Seed 0.
  - Advance: pattern+1 modulo 2^CHANNEL_COUNT.
  - `wrap`=1 on the tick where the output becomes 0 by advancing.
- Mode 1 (walking one):
  - Seed bit0 set (e.g. 0x01).
  - Advance: rotate left by 1.
  - `wrap`=1 on the tick where the output returns to bit0 (every CHANNEL_COUNT ticks).
- Mode 2 (LFSR):
  - 16-bit Fibonacci LFSR, shift left; new bit0 = b15^b13^b12^b10; period 65535.
  - Seed LFSR_SEED.
  - `pattern_out` = LFSR[CHANNEL_COUNT-1:0].
  - `wrap`=1 on the tick where the LFSR advances back to LFSR_SEED.
- Mode 3 (UART 8N1):
  - Channel 0 is the TX line. Channel 1 is frame-active: 1 from START through the last data bit, 0 in STOP and IDLE. Other channels are 0.
  - States: IDLE0 → IDLE1 → START → D0..D7 → STOP → IDLE0, advancing one state per tick. A frame is 12 ticks.
  - TX levels: IDLE=1, START=0, Dn=uart_byte[n] (LSB first), STOP=1.
  - `wrap`=1 on the STOP tick. On that tick uart_byte←uart_byte+1 modulo 256, for use in the next frame.
  - Load outputs IDLE0 with uart_byte=UART_SEED.
- Reset mid-sequence: all state returns to reset values on the next edge, and the next tick reloads the current mode's seed.
- A mode change on the same cycle as the wrap tick: the load wins and `wrap`=0.
- Latency: `pattern_out`, `tick` and `wrap` are all registered and change on the same edge. There is no combinational path from inputs to outputs.

Test Plan:
- Counter, wrap: CHANNEL_COUNT=8, TICK_DIV=4, `mode`=0, `enable`=1 after reset → first `tick` 4 edges after `enable`, `pattern_out`=0x00. Then 0x01, 0x02, … every 4 cycles. On the 256th post-load tick, `pattern_out`=0x00 with `wrap`=1; no other `wrap`.
- Walking one: `mode`=1 → 0x01, 0x02, …, 0x80, then 0x01 with `wrap`=1. Drop `enable` for 10 cycles mid-sequence → output, `tick` spacing and phase are unchanged after resume.
- LFSR: `mode`=2, TICK_DIV=1 → outputs 0xE1 then 0xC3 (state 0x59C3). `wrap`=1 exactly on tick 65535 after load, when the state returns to 0xACE1.
- UART: `mode`=3, TICK_DIV=2 → ch0 over 12 ticks = 1,1,0,1,0,1,0,1,0,1,0,1 (0x55, LSB first). ch1=1 on ticks 3–11. `wrap` on tick 12. The second frame carries 0x56.
- Mode change and reset: switch `mode` 0→1 mid-count → the next tick outputs 0x01 with `wrap`=0. Assert `reset` for 1 cycle mid-UART-frame → all outputs are 0 next cycle, and the next tick restarts at IDLE0 with byte 0x55.
